// File: rtl/uart_rx.sv
// Oversampling UART receiver: start bit, DATA_WIDTH data bits LSB-first, optional parity, one stop bit.
// Each bit is a 2-of-3 majority vote around mid-bit; results are reported as one-cycle strobes.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0]         LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state;
  logic [PRESCALE_W-1:0]   edge_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [PRESCALE_W-1:0]   pre_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    samp_a, samp_b, samp_c;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    par_bad;

  logic [PRESCALE_W-1:0]   half;
  logic                    at_last;
  logic                    maj;

  always_comb begin
    half    = pre_q >> 1;
    at_last = (edge_cnt == (pre_q - ONE));
    maj     = (samp_a & samp_b) | (samp_a & samp_c) | (samp_b & samp_c);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      edge_cnt      <= '0;
      bit_cnt       <= '0;
      pre_q         <= '0;
      par_en_q      <= 1'b0;
      par_typ_q     <= 1'b0;
      samp_a        <= 1'b1;
      samp_b        <= 1'b1;
      samp_c        <= 1'b1;
      shreg         <= '0;
      par_bad       <= 1'b0;
      P_DATA        <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;

      if (state == IDLE) begin
        // The detecting cycle is position 0 of the start bit, so counting resumes at 1.
        if (!RX_IN) begin
          state     <= START;
          edge_cnt  <= ONE;
          bit_cnt   <= '0;
          pre_q     <= Prescale;
          par_en_q  <= PAR_EN;
          par_typ_q <= PAR_TYP;
          par_bad   <= 1'b0;
        end
      end else begin
        edge_cnt <= at_last ? '0 : edge_cnt + ONE;
        if (edge_cnt == half - ONE) samp_a <= RX_IN;
        if (edge_cnt == half)       samp_b <= RX_IN;
        if (edge_cnt == half + ONE) samp_c <= RX_IN;

        if (at_last) begin
          unique case (state)
            START: state <= maj ? IDLE : DATA;
            DATA: begin
              shreg <= {maj, shreg[DATA_WIDTH-1:1]};
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                state   <= par_en_q ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            PARITY: begin
              par_bad <= ((^shreg) ^ par_typ_q) != maj;
              state   <= STOP;
            end
            STOP: begin
              state <= IDLE;
              if (!maj) begin
                framing_error <= 1'b1;
              end else if (par_bad) begin
                parity_error <= 1'b1;
              end else begin
                P_DATA     <= shreg;
                data_valid <= 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus randomized traffic, checked against a frame-level reference model.
module tb_uart_rx;
  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] Prescale = PW'(8);
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          data_valid, parity_error, framing_error;

  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  logic [DW-1:0] model_pdata = '0;

  typedef struct {
    int          kind;   // 1 valid, 2 parity error, 3 framing error
    int          edge_n;
    logic [DW-1:0] data;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  uart_rx #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
    .data_valid(data_valid), .parity_error(parity_error), .framing_error(framing_error)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) ecnt <= ecnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every strobe is logged with the index of the clock edge that produced it.
  always @(negedge CLK) begin
    if (RST && (data_valid || parity_error || framing_error)) begin
      chk("one_strobe", 32'($countones({data_valid, parity_error, framing_error})), 32'd1);
      obs_q.push_back('{data_valid ? 1 : (parity_error ? 2 : 3), ecnt, P_DATA});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic int pick_p();
    case ($urandom_range(0, 2))
      0: return 8;
      1: return 16;
      default: return 32;
    endcase
  endfunction

  // Drives one frame cycle by cycle; may flip the line for one cycle (g_idx/g_pos),
  // scramble configuration inputs after capture, and abort after max_cyc cycles.
  task automatic send_frame(input logic [DW-1:0] data, input int p, input int pe, input int pt,
                            input logic par_bit, input logic stop_bit, input int g_idx,
                            input int g_pos, input int max_cyc, input int scramble, output int e0);
    logic [10:0] fr;
    int nb, cyc;
    Prescale = PW'(p);
    PAR_EN   = pe[0];
    PAR_TYP  = pt[0];
    nb = pe ? 11 : 10;
    fr = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < DW; i++) fr[i+1] = data[i];
    if (pe != 0) fr[9] = par_bit;
    fr[nb-1] = stop_bit;
    e0 = ecnt + 1;
    cyc = 0;
    for (int b = 0; b < nb; b++) begin
      for (int q = 0; q < p; q++) begin
        if (cyc == max_cyc) return;
        RX_IN = fr[b] ^ ((b == g_idx) && (q == g_pos));
        if (scramble != 0 && b == 0 && q == 1) begin
          Prescale = PW'(pick_p());
          PAR_EN   = 1'($urandom);
          PAR_TYP  = 1'($urandom);
        end
        @(posedge CLK);
        #1;
        cyc++;
      end
    end
    RX_IN = 1'b1;
  endtask

  function automatic logic good_par(input logic [DW-1:0] data, input int pt);
    return 1'(($countones(data) + pt) % 2);
  endfunction

  // Reference outcome of a complete frame; strobe appears after stop-bit position P-1.
  task automatic expect_frame(input logic [DW-1:0] data, input int p, input int pe, input int pt,
                              input logic par_bit, input logic stop_bit, input int e0);
    int kind;
    if (!stop_bit) kind = 3;
    else if (pe != 0 && par_bit != good_par(data, pt)) kind = 2;
    else begin
      kind = 1;
      model_pdata = data;
    end
    exp_q.push_back('{kind, e0 + (pe != 0 ? 11 : 10) * p - 1, model_pdata});
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_kind"}, 32'(obs_q[i].kind), 32'(exp_q[i].kind));
      chk({tag, "_edge"}, 32'(obs_q[i].edge_n), 32'(exp_q[i].edge_n));
      chk({tag, "_pdata"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int e0, e1, p, pe, pt, gi, gp;
    logic [DW-1:0] d;
    logic pb, sb;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_pdata", 32'(P_DATA), 32'h0);
    chk("rst_strobes", 32'({data_valid, parity_error, framing_error}), 32'h0);
    RST = 1'b1;
    idle(5);

    send_frame(8'hA5, 8, 0, 0, 1'b0, 1'b1, -1, 0, -1, 0, e0);
    expect_frame(8'hA5, 8, 0, 0, 1'b0, 1'b1, e0);
    idle(5);
    check_events("p8_a5");
    chk("p8_a5_out", 32'(P_DATA), 32'hA5);

    send_frame(8'h3C, 16, 1, 0, 1'b0, 1'b1, -1, 0, -1, 0, e0);
    expect_frame(8'h3C, 16, 1, 0, 1'b0, 1'b1, e0);
    idle(4);
    send_frame(8'h3C, 16, 1, 0, 1'b1, 1'b1, -1, 0, -1, 0, e0);
    expect_frame(8'h3C, 16, 1, 0, 1'b1, 1'b1, e0);
    idle(5);
    check_events("par");
    chk("par_hold", 32'(P_DATA), 32'h3C);

    send_frame(8'h01, 32, 1, 1, 1'b0, 1'b0, -1, 0, -1, 0, e0);
    expect_frame(8'h01, 32, 1, 1, 1'b0, 1'b0, e0);
    idle(5);
    check_events("frm");
    chk("frm_hold", 32'(P_DATA), 32'h3C);

    Prescale = PW'(16);
    RX_IN = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    idle(40);
    check_events("glitch");
    send_frame(8'h5A, 16, 0, 0, 1'b0, 1'b1, -1, 0, -1, 0, e0);
    expect_frame(8'h5A, 16, 0, 0, 1'b0, 1'b1, e0);
    idle(5);
    check_events("after_glitch");

    send_frame(8'hFF, 8, 0, 0, 1'b0, 1'b1, 4, 4, -1, 0, e0);
    expect_frame(8'hFF, 8, 0, 0, 1'b0, 1'b1, e0);
    idle(5);
    check_events("noise");
    chk("noise_out", 32'(P_DATA), 32'hFF);

    send_frame(8'h12, 8, 0, 0, 1'b0, 1'b1, -1, 0, -1, 0, e0);
    send_frame(8'h34, 8, 0, 0, 1'b0, 1'b1, -1, 0, -1, 0, e1);
    expect_frame(8'h12, 8, 0, 0, 1'b0, 1'b1, e0);
    expect_frame(8'h34, 8, 0, 0, 1'b0, 1'b1, e1);
    chk("b2b_gap", 32'(e1 - e0), 32'd80);
    send_frame(8'h77, 8, 0, 0, 1'b0, 1'b1, -1, 0, 30, 0, e0);
    RX_IN = 1'b1;
    RST = 1'b0;
    #1;
    chk("abort_pdata", 32'(P_DATA), 32'h0);
    chk("abort_strobes", 32'({data_valid, parity_error, framing_error}), 32'h0);
    model_pdata = '0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    idle(20);
    check_events("b2b_abort");
    chk("abort_hold", 32'(P_DATA), 32'h0);

    for (int n = 0; n < 40; n++) begin
      p  = pick_p();
      d  = DW'($urandom);
      pe = int'($urandom_range(0, 1));
      pt = int'($urandom_range(0, 1));
      pb = ($urandom_range(0, 3) == 0) ? ~good_par(d, pt) : good_par(d, pt);
      sb = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
      gi = int'($urandom_range(1, pe != 0 ? 10 : 9));
      gp = p / 2 - 1 + int'($urandom_range(0, 2));
      send_frame(d, p, pe, pt, pb, sb, gi, gp, -1, 1, e0);
      expect_frame(d, p, pe, pt, pb, sb, e0);
      idle(int'($urandom_range(0, 3)));
    end
    idle(10);
    check_events("rand");
    chk("rand_pdata", 32'(P_DATA), 32'(model_pdata));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
